seq_count_bcd_updn: RTL and testbench
=====================================

# seq_count_bcd_updn

Parametrised multi-digit BCD-style up/down counter: the next generation of our single-digit decade counter. Each digit counts 0..DIGIT_MAX. Digits cascade ripple-free within one cycle. The counter adds count enable, direction control, synchronous parallel load and a terminal-count output. It serves as a general event/timebase counter in datapath and display-driver blocks.

## Interface
- NDIGITS, default 2: number of cascaded digits, 1..8.
- DIGIT_MAX, default 9: terminal value of every digit, 1..15; each digit counts modulo DIGIT_MAX+1.
- clk  input  1  clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- ld  input  1  synchronous parallel load.
- ld_val  input  4*NDIGITS  load value, one 4-bit digit per nibble, digit 0 in bits [3:0].
- out  output  4*NDIGITS  current count, same nibble layout, registered.
- tc  output  1  terminal count, combinational.

## Operation
- Reset (reset_n=0): all digits cleared to 0 immediately, independent of clk; out = 0 while asserted; tc follows its equation from that state.
- Priority per rising edge: ld > en > hold.
- Load: each digit of out takes min(ld_val digit, DIGIT_MAX); out-of-range nibbles are clamped, never stored. en is ignored in a load cycle; no count occurs.
- Count up (en=1, up=1, ld=0): digit 0 increments. A digit at DIGIT_MAX wraps to 0 and carries into the next digit. A digit advances only when all lower digits are at DIGIT_MAX.
- Count down (en=1, up=0, ld=0): digit 0 decrements. A digit at 0 wraps to DIGIT_MAX and borrows from the next digit. A digit advances only when all lower digits are at 0.
- Full wrap: all digits at DIGIT_MAX counting up gives all 0. All digits at 0 counting down gives all DIGIT_MAX.
- Hold (en=0, ld=0): out unchanged; up may change freely without effect.
- tc = en & ~ld & (up ? all digits == DIGIT_MAX : all digits == 0). tc is asserted in the cycle before the wrap edge. It is suitable as en of a downstream cascaded counter.
- Direction change while enabled takes effect at the next edge. There is no extra state.
- Digit values above DIGIT_MAX are unreachable.

## Timing
- Load-to-out and count-to-out latency: 1 clock edge.
- tc: zero-cycle combinational path from en, ld, up and out. No path from ld_val.
- reset_n assertion is asynchronous. Deassertion is expected synchronous to clk. The first count occurs at the first rising edge with reset_n=1 and en=1.
- Reset mid-count: the count is discarded and out returns to 0 at once. A load or count pending for that edge is lost.

## Configuration
- SEQ_COUNT_BCD_SAT_EN defined: the counter saturates.
  - Counting up at all-DIGIT_MAX holds the value.
  - Counting down at all-0 holds the value.
  - tc still asserts under the same equation.
  - Load and reset behaviour are unchanged.
- SEQ_COUNT_BCD_SAT_EN not defined: wrap-around as described under Operation. This is the default.

## Test plan
All scenarios use NDIGITS=2, DIGIT_MAX=9. Values are written as digit1 digit0.
- Up wrap:
  - Stimulus: reset, then en=1, up=1 for 101 cycles.
  - Required: out steps 00, 01, …, 09, 10, …, 99, 00.
  - Required: tc=1 only while out=99.
- Down wrap:
  - Stimulus: from reset, en=1, up=0.
  - Required: tc=1 while out=00; next out=99, then 98. Across the boundary out 90 → 89.
- Load priority and clamp:
  - Stimulus: ld=1, en=1, ld_val=0x47.
  - Required: out=47 after one edge, not 48; tc=0 in the load cycle; next enabled edge gives 48.
  - Stimulus: ld_val=0xAF.
  - Required: out=99.
- Hold and direction:
  - Stimulus: at out=56, en=0 for 5 cycles while toggling up.
  - Required: out stays 56, tc=0.
  - Stimulus: then en=1, up=0.
  - Required: out=55.
- Async reset mid-count:
  - Stimulus: while counting at 73, pull reset_n low between edges.
  - Required: out=00 before the next edge; holds 00 while low.
  - Stimulus: release reset_n.
  - Required: first enabled edge gives 01.
- Saturation (SEQ_COUNT_BCD_SAT_EN defined):
  - Stimulus: load 98, count up 3 edges.
  - Required: out 99, 99, 99; tc=1.
  - Stimulus: load 01, count down 3 edges.
  - Required: out 00, 00, 00.

Source files
------------

// File: rtl/seq_count_bcd_updn_if.sv
// seq_count_bcd_updn_if
// Control/data bundle for the multi-digit BCD up/down counter.
// The master drives the count controls and the load value. The slave (the
// counter) returns the registered count and the combinational terminal count.
interface seq_count_bcd_updn_if #(
   parameter int NDIGITS = 2
);
   logic                   en;
   logic                   up;
   logic                   ld;
   logic [4*NDIGITS-1:0]   ld_val;
   logic [4*NDIGITS-1:0]   out;
   logic                   tc;

   modport master (
      output en,
      output up,
      output ld,
      output ld_val,
      input  out,
      input  tc
   );

   modport slave (
      input  en,
      input  up,
      input  ld,
      input  ld_val,
      output out,
      output tc
   );
endinterface

// File: rtl/seq_count_bcd_updn.sv
// seq_count_bcd_updn
// Parametrised multi-digit decade-style up/down counter. Each 4-bit digit
// counts 0..DIGIT_MAX and the digits cascade within a single clock, so the
// whole count moves by exactly one per enabled edge.
//
// Per-edge priority: load > count > hold. Loaded nibbles above DIGIT_MAX are
// clamped to DIGIT_MAX so out-of-range digit values can never be stored.
// tc is combinational and is meant to feed the en of a downstream counter.
//
// Optional feature macro: SEQ_COUNT_BCD_SAT_EN
//   defined     -> counting up at all-DIGIT_MAX or down at all-0 holds the value
//   not defined -> full wrap-around (default build)
module seq_count_bcd_updn #(
   parameter int NDIGITS   = 2,
   parameter int DIGIT_MAX = 9
) (
   input  logic                 clk,
   input  logic                 reset_n,
   seq_count_bcd_updn_if.slave  bus
);

   localparam int             W        = 4 * NDIGITS;
   localparam logic [3:0]     DMAX     = 4'(DIGIT_MAX);
   localparam logic [3:0]     DZERO    = 4'd0;
   localparam logic [W-1:0]   ALL_ZERO = {W{1'b0}};
   localparam logic [W-1:0]   ALL_MAX  = {NDIGITS{DMAX}};

   // Digit helpers: clamp a loaded nibble, step a digit up or down with wrap.
   function automatic logic [3:0] clamp_digit(input logic [3:0] d);
      logic [3:0] r;
      if (d > DMAX) begin
         r = DMAX;
      end else begin
         r = d;
      end
      return r;
   endfunction

   function automatic logic [3:0] inc_digit(input logic [3:0] d);
      logic [3:0] r;
      if (d == DMAX) begin
         r = DZERO;
      end else begin
         r = d + 4'd1;
      end
      return r;
   endfunction

   function automatic logic [3:0] dec_digit(input logic [3:0] d);
      logic [3:0] r;
      if (d == DZERO) begin
         r = DMAX;
      end else begin
         r = d - 4'd1;
      end
      return r;
   endfunction

   logic [W-1:0] cnt_r;
   logic [W-1:0] cnt_nxt_s;
   logic         all_max_s;
   logic         all_zero_s;
   logic         at_end_s;
   logic         sat_hold_s;

   assign all_max_s  = (cnt_r == ALL_MAX);
   assign all_zero_s = (cnt_r == ALL_ZERO);

   // End of range in the current direction: the state in which the next
   // enabled edge would wrap the whole counter.
   assign at_end_s = bus.up ? all_max_s : all_zero_s;

`ifdef SEQ_COUNT_BCD_SAT_EN
   // Saturating build: suppress the count that would wrap the whole counter.
   assign sat_hold_s = at_end_s;
`else
   // Wrapping build: the count is never suppressed.
   assign sat_hold_s = 1'b0;
`endif

   // Terminal count: asserted the cycle before the wrap edge; no path from ld_val.
   assign bus.tc = bus.en & ~bus.ld & at_end_s;

   // The count register is the output; nothing combinational sits after it.
   assign bus.out = cnt_r;

   // Next-state: load with clamp, or ripple-free cascaded count, or hold.
   always_comb begin
      logic adv_v;
      cnt_nxt_s = cnt_r;
      adv_v     = 1'b1;
      if (bus.ld) begin
         for (int i = 0; i < NDIGITS; i++) begin
            cnt_nxt_s[4*i +: 4] = clamp_digit(bus.ld_val[4*i +: 4]);
         end
      end else if (bus.en && !sat_hold_s) begin
         // adv_v is true for digit i only when every lower digit sits at
         // its end value for the current direction.
         for (int i = 0; i < NDIGITS; i++) begin
            if (adv_v) begin
               if (bus.up) begin
                  cnt_nxt_s[4*i +: 4] = inc_digit(cnt_r[4*i +: 4]);
               end else begin
                  cnt_nxt_s[4*i +: 4] = dec_digit(cnt_r[4*i +: 4]);
               end
            end else begin
               cnt_nxt_s[4*i +: 4] = cnt_r[4*i +: 4];
            end
            if (bus.up) begin
               adv_v = adv_v & (cnt_r[4*i +: 4] == DMAX);
            end else begin
               adv_v = adv_v & (cnt_r[4*i +: 4] == DZERO);
            end
         end
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Count register with asynchronous clear; any pending load/count is lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r <= ALL_ZERO;
      end else begin
         cnt_r <= cnt_nxt_s;
      end
   end

endmodule

// File: tb/tb_seq_count_bcd_updn.sv
// tb_seq_count_bcd_updn
// Directed and randomized bench for seq_count_bcd_updn (NDIGITS=2, DIGIT_MAX=9).
// The reference model keeps the count as a plain integer modulo
// (DIGIT_MAX+1)**NDIGITS and converts it to digits only for comparison.
module tb_seq_count_bcd_updn;

   localparam int ND = 2;
   localparam int DM = 9;
   localparam int W  = 4 * ND;
   localparam int R  = DM + 1;
   localparam int M  = R ** ND;
`ifdef SEQ_COUNT_BCD_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;
   int   mv;

   seq_count_bcd_updn_if #(.NDIGITS(ND)) bus ();

   seq_count_bcd_updn #(
      .NDIGITS   (ND),
      .DIGIT_MAX (DM)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int           t;
      r = '0;
      t = v;
      for (int i = 0; i < ND; i++) begin
         r[4*i +: 4] = 4'(t % R);
         t = t / R;
      end
      return r;
   endfunction

   function automatic int load_value(input logic [W-1:0] lv);
      int acc;
      int mul;
      int n;
      acc = 0;
      mul = 1;
      for (int i = 0; i < ND; i++) begin
         n = int'(lv[4*i +: 4]);
         if (n > DM) n = DM;
         acc = acc + n * mul;
         mul = mul * R;
      end
      return acc;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, check tc before the edge, update model, check out.
   task automatic cycle(input logic e, input logic u, input logic l,
                        input logic [W-1:0] lv, input string tag);
      logic exp_tc;
      bus.en     = e;
      bus.up     = u;
      bus.ld     = l;
      bus.ld_val = lv;
      #1;
      exp_tc = e & ~l & (u ? (mv == M - 1) : (mv == 0));
      check({tag, ":tc"}, 32'(bus.tc), 32'(exp_tc));
      @(posedge clk);
      if (l) begin
         mv = load_value(lv);
      end else if (e) begin
         if (u) begin
            if (!(SAT && mv == M - 1)) mv = (mv + 1) % M;
         end else begin
            if (!(SAT && mv == 0)) mv = (mv + M - 1) % M;
         end
      end
      #1;
      check({tag, ":out"}, 32'(bus.out), 32'(to_bcd(mv)));
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset_n = 1'b0;
      mv      = 0;
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      mv         = 0;
      reset_n    = 1'b0;
      bus.en     = 1'b0;
      bus.up     = 1'b0;
      bus.ld     = 1'b0;
      bus.ld_val = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset:out", 32'(bus.out), 32'(to_bcd(0)));
      check("reset:tc", 32'(bus.tc), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Up wrap: 00 .. 99 .. 00, tc only at 99
      for (int i = 0; i < 101; i++) cycle(1'b1, 1'b1, 1'b0, 8'h00, "upwrap");

      // Down wrap from reset: tc at 00, then 99, 98
      pulse_reset();
      cycle(1'b1, 1'b0, 1'b0, 8'h00, "dn00");
      cycle(1'b1, 1'b0, 1'b0, 8'h00, "dn99");
      cycle(1'b0, 1'b0, 1'b1, 8'h90, "ld90");
      cycle(1'b1, 1'b0, 1'b0, 8'h00, "dn90");

      // Load priority over count, then clamp
      cycle(1'b1, 1'b1, 1'b1, 8'h47, "ld47");
      cycle(1'b1, 1'b1, 1'b0, 8'h00, "up47");
      cycle(1'b0, 1'b1, 1'b1, 8'hAF, "ldAF");
      cycle(1'b1, 1'b0, 1'b1, 8'hF3, "ldF3");

      // Hold with up toggling, then count down
      cycle(1'b0, 1'b0, 1'b1, 8'h56, "ld56");
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'(i % 2), 1'b0, 8'h00, "hold");
      cycle(1'b1, 1'b0, 1'b0, 8'h00, "dn56");

      // Async reset mid-count at 73
      cycle(1'b0, 1'b1, 1'b1, 8'h72, "ld72");
      cycle(1'b1, 1'b1, 1'b0, 8'h00, "up72");
      bus.en  = 1'b1;
      bus.up  = 1'b1;
      reset_n = 1'b0;
      mv      = 0;
      #1;
      check("arst:now", 32'(bus.out), 32'(to_bcd(0)));
      @(posedge clk);
      #1;
      check("arst:hold", 32'(bus.out), 32'(to_bcd(0)));
      @(negedge clk);
      reset_n = 1'b1;
      cycle(1'b1, 1'b1, 1'b0, 8'h00, "arst:first");

      // End-of-range behaviour (saturates or wraps per build)
      cycle(1'b0, 1'b1, 1'b1, 8'h98, "ld98");
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 8'h00, "satup");
      cycle(1'b0, 1'b0, 1'b1, 8'h01, "ld01");
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 8'h00, "satdn");

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 9) == 0), W'($urandom), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
